// File: rtl/map_scroller.sv
// -----------------------------------------------------------------------------
// map_scroller
//
// Scrolls the obstacle-map ROM leftward as one continuous bit stream, one
// column per scroll tick, and exposes a 32-column visible window. The bird's
// column is checked against the window every RUN cycle; a hit freezes the
// scroller in HALT with a sticky collide flag.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   single-cycle pulse, (re)starts scrolling from row 0
//   pause         in   level, freezes divider and scrolling in RUN
//   scroll_period in   clocks per scroll tick (0 treated as 1)
//   bird_valid    in   bird_col is meaningful this cycle
//   bird_col      in   window column occupied by the bird
//   rom_addr      out  registered ROM row address
//   rom_data      in   ROM row for rom_addr (combinational ROM), bit 0 leftmost
//   window        out  visible map, window[0] is the leftmost column
//   running       out  high while scrolling (RUN)
//   collide       out  sticky hit flag, high in HALT
//   score         out  rows consumed since start, saturating at 255
// -----------------------------------------------------------------------------
module map_scroller #(
    parameter int ROWS_LOG2 = 4,
    parameter int PER_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 pause,
    input  logic [PER_W-1:0]     scroll_period,
    input  logic                 bird_valid,
    input  logic [4:0]           bird_col,
    output logic [ROWS_LOG2-1:0] rom_addr,
    input  logic [0:31]          rom_data,
    output logic [0:31]          window,
    output logic                 running,
    output logic                 collide,
    output logic [7:0]           score
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME0,
        S_PRIME1,
        S_RUN,
        S_HALT
    } state_t;

    localparam logic [PER_W-1:0]     PER_ONE  = {{(PER_W-1){1'b0}}, 1'b1};
    localparam logic [ROWS_LOG2-1:0] ADDR_ONE = {{(ROWS_LOG2-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [0:31]           window_q, window_d;
    logic [0:31]           buffer_q, buffer_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [PER_W-1:0]      div_cnt_q, div_cnt_d;
    logic [ROWS_LOG2-1:0]  rom_addr_q, rom_addr_d;
    logic [7:0]            score_q, score_d;
    logic                  collide_q, collide_d;
    logic                  running_q, running_d;

    logic [PER_W-1:0]      period_eff;
    logic                  tick;
    logic                  hit;

    always_comb begin
        // A zero period would never reach its terminal count; run it as 1.
        period_eff = (scroll_period == '0) ? PER_ONE : scroll_period;
        tick       = (div_cnt_q == (period_eff - PER_ONE));
        hit        = bird_valid & window_q[bird_col];

        state_d    = state_q;
        window_d   = window_q;
        buffer_d   = buffer_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        rom_addr_d = rom_addr_q;
        score_d    = score_q;
        collide_d  = collide_q;

        if (start) begin
            // start outranks hit and tick in every state
            state_d    = S_PRIME0;
            rom_addr_d = '0;
            score_d    = '0;
            collide_d  = 1'b0;
            bit_cnt_d  = '0;
            div_cnt_d  = '0;
        end else begin
            case (state_q)
                S_PRIME0: begin
                    window_d   = rom_data;              // row 0
                    rom_addr_d = rom_addr_q + ADDR_ONE;
                    state_d    = S_PRIME1;
                end
                S_PRIME1: begin
                    buffer_d   = rom_data;              // row 1
                    rom_addr_d = rom_addr_q + ADDR_ONE;
                    state_d    = S_RUN;
                end
                S_RUN: begin
                    if (hit) begin
                        // the hit suppresses any shift due this cycle
                        collide_d = 1'b1;
                        state_d   = S_HALT;
                    end else if (!pause) begin
                        if (tick) begin
                            div_cnt_d = '0;
                            window_d  = {window_q[1:31], buffer_q[0]};
                            if (bit_cnt_q != 5'd31) begin
                                buffer_d  = {buffer_q[1:31], 1'b0};
                                bit_cnt_d = bit_cnt_q + 5'd1;
                            end else begin
                                // last bit of this row consumed: rom_addr
                                // already points at the following row
                                buffer_d   = rom_data;
                                rom_addr_d = rom_addr_q + ADDR_ONE;
                                bit_cnt_d  = '0;
                                if (score_q != 8'hFF) begin
                                    score_d = score_q + 8'd1;
                                end
                            end
                        end else begin
                            div_cnt_d = div_cnt_q + PER_ONE;
                        end
                    end
                end
                default: begin
                    // IDLE and HALT hold everything until start
                end
            endcase
        end

        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            window_q   <= '0;
            buffer_q   <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            rom_addr_q <= '0;
            score_q    <= '0;
            collide_q  <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            window_q   <= window_d;
            buffer_q   <= buffer_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            rom_addr_q <= rom_addr_d;
            score_q    <= score_d;
            collide_q  <= collide_d;
            running_q  <= running_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign window   = window_q;
    assign running  = running_q;
    assign collide  = collide_q;
    assign score    = score_q;

endmodule

// File: tb/tb_map_scroller.sv
// -----------------------------------------------------------------------------
// tb_map_scroller
//
// Bench for map_scroller. The reference model tracks the scroll position as
// the number of ticks since start; the expected window is the 32 stream bits
// starting at that position, where stream bit k is bit (k mod 32) of ROM row
// (k / 32) mod 16. Address and score follow from the position by division.
// -----------------------------------------------------------------------------
module tb_map_scroller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        pause;
    logic [15:0] scroll_period;
    logic        bird_valid;
    logic [4:0]  bird_col;
    logic [3:0]  rom_addr;
    logic [0:31] rom_data;
    logic [0:31] window;
    logic        running;
    logic        collide;
    logic [7:0]  score;

    logic [0:31] rom_mem [0:15];

    int n_tests = 0;
    int n_fail  = 0;

    map_scroller #(.ROWS_LOG2(4), .PER_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .pause         (pause),
        .scroll_period (scroll_period),
        .bird_valid    (bird_valid),
        .bird_col      (bird_col),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .window        (window),
        .running       (running),
        .collide       (collide),
        .score         (score)
    );

    assign rom_data = rom_mem[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_P0 = 1, M_P1 = 2, M_RUN = 3, M_HALT = 4;

    int          m_state;
    int          m_pos;
    int          m_cnt;
    logic        m_collide;
    logic [0:31] m_window;

    function automatic logic stream_bit(int k);
        logic [0:31] row;
        row = rom_mem[(k / 32) % 16];
        return row[k % 32];
    endfunction

    function automatic logic [0:31] win_at(int pos);
        logic [0:31] w;
        for (int j = 0; j < 32; j++) w[j] = stream_bit(pos + j);
        return w;
    endfunction

    function automatic int period_of(logic [15:0] p);
        return (p == 16'd0) ? 1 : int'(p);
    endfunction

    function automatic logic [3:0] exp_addr();
        case (m_state)
            M_P1:           return 4'd1;
            M_RUN, M_HALT:  return 4'((m_pos / 32 + 2) % 16);
            default:        return 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] exp_score();
        if (m_state == M_RUN || m_state == M_HALT)
            return (m_pos / 32 > 255) ? 8'd255 : 8'(m_pos / 32);
        return 8'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state   <= M_IDLE;
            m_pos     <= 0;
            m_cnt     <= 0;
            m_collide <= 1'b0;
            m_window  <= '0;
        end else if (start) begin
            m_state   <= M_P0;
            m_pos     <= 0;
            m_cnt     <= 0;
            m_collide <= 1'b0;
        end else begin
            case (m_state)
                M_P0: begin
                    m_window <= win_at(0);
                    m_state  <= M_P1;
                end
                M_P1: m_state <= M_RUN;
                M_RUN: begin
                    if (bird_valid && m_window[bird_col]) begin
                        m_collide <= 1'b1;
                        m_state   <= M_HALT;
                    end else if (!pause) begin
                        if (m_cnt == period_of(scroll_period) - 1) begin
                            m_cnt    <= 0;
                            m_pos    <= m_pos + 1;
                            m_window <= win_at(m_pos + 1);
                        end else begin
                            m_cnt <= m_cnt + 1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; scroll_period = 16'd3;
        bird_valid = 1'b0; bird_col = 5'd0;
        for (int i = 0; i < 16; i++) rom_mem[i] = {i[3:0], 28'h0};
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (window !== 32'h0)  begin n_fail++; $display("FAIL reset_window: got %h expected 0", window); end
        n_tests++; if (rom_addr !== 4'h0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", rom_addr); end
        n_tests++; if (running !== 1'b0)  begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
        n_tests++; if (collide !== 1'b0)  begin n_fail++; $display("FAIL reset_collide: got %b expected 0", collide); end
        n_tests++; if (score !== 8'h0)    begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (window !== 32'h0)  begin n_fail++; $display("FAIL prime_window: got %h expected 0", window); end
        n_tests++; if (rom_addr !== 4'd2) begin n_fail++; $display("FAIL prime_addr: got %0d expected 2", rom_addr); end
        n_tests++; if (running !== 1'b1)  begin n_fail++; $display("FAIL prime_running: got %b expected 1", running); end
        $display("[TB] reset and prime done");
    endtask

    // Continues from test_reset: scrolling with period 3 already in RUN.
    task automatic test_scroll();
        for (int c = 0; c < 96; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (window !== m_window) begin
                n_fail++; $display("FAIL scroll_window_c%0d: got %h expected %h", c, window, m_window);
            end
        end
        n_tests++; if (window !== 32'h1000_0000) begin n_fail++; $display("FAIL scroll_row1: got %h expected 10000000", window); end
        n_tests++; if (rom_addr !== 4'd3) begin n_fail++; $display("FAIL scroll_addr: got %0d expected 3", rom_addr); end
        n_tests++; if (score !== 8'd1)    begin n_fail++; $display("FAIL scroll_score: got %0d expected 1", score); end
        $display("[TB] scroll and reload done");
    endtask

    task automatic test_wrap();
        bit seen512 = 0;
        for (int i = 0; i < 16; i++) rom_mem[i] = $urandom;
        scroll_period = 16'd1; bird_valid = 1'b0; pause = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 8300; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (rom_addr !== exp_addr() || score !== exp_score()) begin
                n_fail++;
                $display("FAIL wrap_c%0d: got addr %0d score %0d expected addr %0d score %0d",
                         c, rom_addr, score, exp_addr(), exp_score());
            end
            if (m_pos == 512 && !seen512) begin
                seen512 = 1;
                n_tests++; if (score !== 8'd16) begin n_fail++; $display("FAIL wrap_score16: got %0d expected 16", score); end
            end
        end
        n_tests++; if (score !== 8'd255) begin n_fail++; $display("FAIL wrap_saturate: got %0d expected 255", score); end
        $display("[TB] address wrap and saturation done");
    endtask

    task automatic test_collide();
        for (int i = 0; i < 16; i++) rom_mem[i] = 32'h0;
        rom_mem[0] = 32'h0400_0000;    // column 5 of row 0
        scroll_period = 16'd1; bird_col = 5'd5; bird_valid = 1'b1; pause = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (running !== 1'b1 || collide !== 1'b0) begin n_fail++; $display("FAIL collide_entry: got run %b col %b expected run 1 col 0", running, collide); end
        @(posedge clk); #1;
        n_tests++; if (collide !== 1'b1) begin n_fail++; $display("FAIL collide_set: got %b expected 1", collide); end
        n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL collide_halt: got running %b expected 0", running); end
        n_tests++; if (window !== 32'h0400_0000) begin n_fail++; $display("FAIL collide_noshift: got %h expected 04000000", window); end
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (collide !== 1'b1 || window !== 32'h0400_0000 || rom_addr !== 4'd2)
            begin n_fail++; $display("FAIL collide_frozen: got col %b win %h addr %0d expected 1 04000000 2", collide, window, rom_addr); end
        bird_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++; if (collide !== 1'b0) begin n_fail++; $display("FAIL collide_clear: got %b expected 0", collide); end
        repeat (2) @(posedge clk);
        $display("[TB] collision done");
    endtask

    task automatic test_pause();
        logic [0:31] held;
        int          col;
        for (int i = 0; i < 16; i++) rom_mem[i] = $urandom | 32'h8000_0001;
        scroll_period = 16'd0; bird_valid = 1'b0; pause = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            n_tests++; if (window !== m_window) begin n_fail++; $display("FAIL p0_shift: got %h expected %h", window, m_window); end
        end
        pause = 1'b1;
        held  = m_window;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (window !== held || dut.bit_cnt_q !== 5'(m_pos % 32) || dut.div_cnt_q !== 16'd0) begin
                n_fail++;
                $display("FAIL pause_hold_c%0d: got win %h bit %0d div %0d expected %h %0d 0",
                         c, window, dut.bit_cnt_q, dut.div_cnt_q, held, m_pos % 32);
            end
        end
        col = 0;
        for (int j = 31; j >= 0; j--) if (held[j]) col = j;
        bird_col = 5'(col); bird_valid = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (collide !== 1'b1 || window !== held)
            begin n_fail++; $display("FAIL pause_hit: got col %b win %h expected 1 %h", collide, window, held); end
        bird_valid = 1'b0; pause = 1'b0;
        $display("[TB] pause and period 0 done");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 16; i++) rom_mem[i] = $urandom | 32'h8000_0001;
        scroll_period = 16'd2; bird_valid = 1'b0; pause = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (80) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++; if (window !== 32'h0 || rom_addr !== 4'h0 || score !== 8'h0 || running !== 1'b0 || collide !== 1'b0)
            begin n_fail++; $display("FAIL async_clear: got win %h addr %0d score %0d run %b col %b expected all 0", window, rom_addr, score, running, collide); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            n_tests++; if (window !== 32'h0 || running !== 1'b0 || rom_addr !== 4'h0)
                begin n_fail++; $display("FAIL async_idle: got win %h run %b addr %0d expected 0 0 0", window, running, rom_addr); end
        end
        $display("[TB] async reset done");
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 16; i++) rom_mem[i] = $urandom;
            scroll_period = 16'($urandom_range(0, 4));
            pause = 1'b0; bird_valid = 1'b0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int c = 0; c < 300; c++) begin
                pause      = ($urandom_range(0, 4) == 0);
                bird_valid = ($urandom_range(0, 40) == 0);
                bird_col   = 5'($urandom_range(0, 31));
                @(posedge clk); #1;
                n_tests++;
                if (window !== m_window || rom_addr !== exp_addr() || score !== exp_score() ||
                    collide !== m_collide || running !== (m_state == M_RUN)) begin
                    n_fail++;
                    $display("FAIL random_it%0d_c%0d: got win %h addr %0d score %0d col %b run %b expected %h %0d %0d %b %b",
                             it, c, window, rom_addr, score, collide, running,
                             m_window, exp_addr(), exp_score(), m_collide, (m_state == M_RUN));
                end
            end
            $display("[TB] random run %0d period %0d done", it, scroll_period);
        end
        pause = 1'b0; bird_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scroll();
        test_wrap();
        test_collide();
        test_pause();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/map_scroller.md
# map_scroller

Reads the 16-row by 32-bit obstacle-map ROM and scrolls it leftward as one continuous bit stream, one column per scroll tick. It exposes a 32-column visible window to the renderer and checks the bird's column against that window to flag a collision. It sits between the map ROM (combinational, 4-bit address, 32-bit row out, bit 0 = leftmost) and the game control and VGA logic.

## Interface
- `ROWS_LOG2`, default 4: ROM address width. Row index wraps modulo 2^ROWS_LOG2.
- `PER_W`, default 16: width of the scroll period input.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start` in 1: single-cycle pulse; (re)starts scrolling from row 0 in any state.
- `pause` in 1: level; freezes the divider and scrolling while high (RUN only).
- `scroll_period` in PER_W: clocks per scroll tick. Value 0 is treated as 1.
- `bird_valid` in 1: bird column is meaningful this cycle.
- `bird_col` in 5: window column occupied by the bird, 0..31.
- `rom_addr` out ROWS_LOG2: registered ROM row address.
- `rom_data` in [0:31]: ROM row for the current `rom_addr`, valid in the same cycle.
- `window` out [0:31]: visible map; `window[0]` is the leftmost column.
- `running` out 1: high in RUN.
- `collide` out 1: sticky hit flag, high in HALT.
- `score` out 8: count of rows consumed since start, saturates at 255.

## Operation
- **Internal registers:**
  - `buffer[0:31]`: next row being shifted in.
  - `bit_cnt` (5 bits): bits consumed from `buffer`.
  - `div_cnt` (PER_W bits): tick divider.
  - `state`: one of IDLE, PRIME0, PRIME1, RUN, HALT.
- **Reset values:** all outputs and registers are 0, and state is IDLE.
- **IDLE:** hold. `start` moves to PRIME0 and clears `rom_addr`, `score`, `collide`, `bit_cnt` and `div_cnt`.
- **PRIME0:** `window <= rom_data` (row 0), `rom_addr <= 1`, then go to PRIME1.
- **PRIME1:** `buffer <= rom_data` (row 1), `rom_addr <= 2`, then go to RUN.
- **RUN, divider:** when not paused, `div_cnt` counts 0..P-1, where P = max(`scroll_period`, 1). A tick occurs on the cycle `div_cnt == P-1`, and `div_cnt` then returns to 0.
- **RUN, on tick with no hit:**
  - `window <= {window[1:31], buffer[0]}`.
  - If `bit_cnt != 31`: `buffer <= {buffer[1:31], 0}` and `bit_cnt` increments.
  - If `bit_cnt == 31`: `buffer <= rom_data`, `rom_addr <= rom_addr + 1` (wraps from 15 to 0), `bit_cnt <= 0`, and `score` increments (saturating).
- **Hit:** `bird_valid & window[bird_col]` evaluated in RUN, every cycle, paused or not.
  - On a hit: `collide <= 1` and go to HALT. No shift occurs that cycle, even if a tick coincides; the hit wins.
- **HALT:** `window`, `rom_addr` and `score` are frozen and `collide` stays 1. `start` moves to PRIME0.
- **`start` in PRIME0, PRIME1 or RUN:** restarts at PRIME0 with the same clears. `start` has priority over hit and tick.
- **`pause` outside RUN:** ignored.
- **Reset mid-operation:** asserting `rst_n` low returns immediately to the reset values.

## Timing
- The ROM is combinational. `rom_addr` changes only on clock edges, and `rom_data` is sampled at the next edge.
- `start` at edge N:
  - PRIME0 at N+1, with `window` = row 0 after N+1.
  - `buffer` = row 1 after N+2.
  - RUN from N+2, with `running = 1` after N+2.
- First tick: P cycles after RUN entry.
- One row is consumed every 32 ticks, i.e. 32·P clocks.
- `collide` rises one cycle after the offending window/bird condition is present.
- `score` updates on the same edge as the buffer reload.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- **Reset and prime.** Bench ROM `rom[i] = {i[3:0], 28'h0}`; hold reset, then pulse `start`.
  - During reset: all outputs are 0.
  - 2 cycles after `start`: `window = 32'h0000_0000`, `rom_addr = 2`, `running = 1`.
- **Scroll and reload.** `scroll_period = 3`, `bird_valid = 0`, run 32 ticks (96 clocks).
  - `window` equals row 1 (`32'h1000_0000`).
  - `rom_addr = 3`, `score = 1`.
  - Ticks are spaced exactly 3 clocks apart.
- **Address wrap.** `scroll_period = 1`, run 16×32 ticks.
  - `rom_addr` sequence goes …15, 0, 1…
  - `score` = 16 after 512 ticks, and saturates at 255 after 255×32+ ticks.
- **Collision, coincident with tick.** Set `rom[0][5] = 1`, `bird_col = 5`, `bird_valid = 1`, `start`.
  - `collide = 1` one cycle after RUN entry; state is HALT.
  - `window` is unchanged despite a tick on the same cycle.
  - `start` then clears `collide`.
- **Pause and period 0.** `scroll_period = 0`: `window` shifts every clock. `pause` high for 10 clocks:
  - `window`, `div_cnt` and `bit_cnt` do not change.
  - A hit while paused still sets `collide`.
- **Async reset mid-run.** Drop `rst_n` asynchronously between edges during RUN.
  - Outputs clear immediately, without waiting for a clock edge.
  - After release, nothing moves until `start`.
